// File: rtl/irq_controller.sv
// irq_controller: synchronises NUM_CH raw interrupt sources and latches each
// event into a pending bit. Masking and fixed priority (lowest index wins)
// select one request, which the CPU takes with an Ack/Done handshake.
//
// Handshake: IRQ_Req stays high, with IRQ_ID stable, until the CPU asserts
// IRQ_Ack on a rising CLK edge. That edge moves the controller into service,
// clears the acknowledged pending bit and drops IRQ_Req. IRQ_Done on a later
// edge ends service. If the requested bit disappears before the Ack (because
// software cleared it or masked it), the request is withdrawn. Ack outside
// REQ and Done outside SERVICE have no effect.
module irq_controller #(
    parameter int                NUM_CH      = 5,
    parameter int                SYNC_STAGES = 2,
    parameter logic [NUM_CH-1:0] EDGE_MASK   = '1,
    localparam int               ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [NUM_CH-1:0] IRQ_In,
    input  logic [NUM_CH-1:0] Mask_Data,
    input  logic              Mask_Write,
    input  logic [NUM_CH-1:0] Pend_Clr_Data,
    input  logic              Pend_Clr_Write,
    input  logic              IRQ_Ack,
    input  logic              IRQ_Done,
    output logic              IRQ_Req,
    output logic [ID_W-1:0]   IRQ_ID,
    output logic              In_Service,
    output logic [NUM_CH-1:0] Pending,
    output logic [NUM_CH-1:0] Mask,
    output logic [1:0]        Dbg_State
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] hist_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] sync_lvl;
    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] cur_oh;
    logic [NUM_CH-1:0] ack_clr;
    logic [NUM_CH-1:0] clr_vec;
    logic [ID_W-1:0]   win_id;
    logic              any_eligible;
    logic              ack_take;

    // Synchroniser chain plus one history flop per channel for edge detect.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= IRQ_In;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_lvl;
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    // Edge channels fire on a rising synchronised level; level channels fire
    // on every cycle the synchronised level is high.
    assign evt      = sync_lvl & (~EDGE_MASK | ~hist_q);
    assign eligible = pending_q & mask_q;
    assign cur_oh   = NUM_CH'(1) << id_q;
    assign ack_take = (state_q == REQ) && IRQ_Ack;
    assign ack_clr  = ack_take ? cur_oh : '0;

    // Pending update: clears first, then new events on top so no event is lost.
    always_comb begin
        clr_vec   = ack_clr;
        pending_d = pending_q;
        if (Pend_Clr_Write) begin
            clr_vec = clr_vec | Pend_Clr_Data;
        end
        pending_d = (pending_q & ~clr_vec) | evt;
    end

    // Mask register loads only on an explicit write.
    always_comb begin
        mask_d = mask_q;
        if (Mask_Write) begin
            mask_d = Mask_Data;
        end
    end

    // Fixed-priority pick: scan downwards so the lowest eligible index wins.
    always_comb begin
        win_id       = '0;
        any_eligible = |eligible;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // Handshake FSM next state. Arbitration happens only in IDLE; the
    // latched ID is held through REQ and SERVICE.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (any_eligible) begin
                    id_d    = win_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (IRQ_Ack) begin
                    state_d = SERVICE;
                end else if ((cur_oh & eligible) == '0) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (IRQ_Done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, ID, pending and mask registers.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= IDLE;
            id_q      <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign IRQ_Req    = (state_q == REQ);
    assign In_Service = (state_q == SERVICE);
    assign IRQ_ID     = id_q;
    assign Pending    = pending_q;
    assign Mask       = mask_q;
    assign Dbg_State  = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: one record per clock cycle holding the inputs for
// that cycle and the outputs expected just after its rising edge, plus a
// hand-written sequence around an asynchronous reset in mid-service.
module tb_irq_controller;

    localparam int NCH = 5;
    localparam int IDW = 3;
    localparam int EW  = 1 + IDW + 1 + NCH + NCH;

    typedef struct {
        logic [NCH-1:0] irq;
        logic           mw;
        logic [NCH-1:0] md;
        logic           cw;
        logic [NCH-1:0] cd;
        logic           ack;
        logic           done;
        logic           e_req;
        logic [IDW-1:0] e_id;
        logic           e_svc;
        logic [NCH-1:0] e_pend;
        logic [NCH-1:0] e_mask;
    } vec_t;

    logic           clk;
    logic           clr;
    logic [NCH-1:0] irq_in;
    logic [NCH-1:0] mask_data;
    logic           mask_write;
    logic [NCH-1:0] pend_clr_data;
    logic           pend_clr_write;
    logic           irq_ack;
    logic           irq_done;
    logic           irq_req;
    logic [IDW-1:0] irq_id;
    logic           in_service;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] mask;
    logic [1:0]     dbg_state;

    logic [EW-1:0]  exp_q[$];
    vec_t           tbl[$];
    int             n_vec;
    int             n_miss;

    irq_controller #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (2),
        .EDGE_MASK   (5'b11110)
    ) dut (
        .CLK            (clk),
        .CLR            (clr),
        .IRQ_In         (irq_in),
        .Mask_Data      (mask_data),
        .Mask_Write     (mask_write),
        .Pend_Clr_Data  (pend_clr_data),
        .Pend_Clr_Write (pend_clr_write),
        .IRQ_Ack        (irq_ack),
        .IRQ_Done       (irq_done),
        .IRQ_Req        (irq_req),
        .IRQ_ID         (irq_id),
        .In_Service     (in_service),
        .Pending        (pending),
        .Mask           (mask),
        .Dbg_State      (dbg_state)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, need completion", n_vec);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [NCH-1:0] irq, input logic mw, input logic [NCH-1:0] md,
                                input logic cw, input logic [NCH-1:0] cd, input logic ack, input logic done,
                                input logic er, input logic [IDW-1:0] eid, input logic es,
                                input logic [NCH-1:0] ep, input logic [NCH-1:0] em);
        vec_t v;
        v.irq = irq; v.mw = mw; v.md = md; v.cw = cw; v.cd = cd; v.ack = ack; v.done = done;
        v.e_req = er; v.e_id = eid; v.e_svc = es; v.e_pend = ep; v.e_mask = em;
        return v;
    endfunction

    // Pop the oldest expectation and compare it with the current DUT outputs.
    task automatic check_out(input string name);
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        got = {irq_req, irq_id, in_service, pending, mask};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: got an output sample, need a queued expectation", name);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_miss++;
                $display("FAIL %s: got req=%b id=%0d svc=%b pend=%b mask=%b (state %0d), need req=%b id=%0d svc=%b pend=%b mask=%b",
                         name, got[14], got[13:11], got[10], got[9:5], got[4:0], dbg_state,
                         exp[14], exp[13:11], exp[10], exp[9:5], exp[4:0]);
            end
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        irq_in         = v.irq;
        mask_write     = v.mw;
        mask_data      = v.md;
        pend_clr_write = v.cw;
        pend_clr_data  = v.cd;
        irq_ack        = v.ack;
        irq_done       = v.done;
        exp_q.push_back({v.e_req, v.e_id, v.e_svc, v.e_pend, v.e_mask});
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        clr            = 1'b0;
        irq_in         = '0;
        mask_data      = '0;
        mask_write     = 1'b0;
        pend_clr_data  = '0;
        pend_clr_write = 1'b0;
        irq_ack        = 1'b0;
        irq_done       = 1'b0;

        // Fields: irq, mw, md, cw, cd, ack, done | req, id, svc, pend, mask
        // Reset state
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000));
        // Single edge on channel 3
        tbl.push_back(mk(5'b00000, 1, 5'b11111, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b01000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b01000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b01000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b01000, 5'b11111));
        tbl.push_back(mk(5'b01000, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 3, 0, 5'b01000, 5'b11111));
        tbl.push_back(mk(5'b01000, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 3, 0, 5'b01000, 5'b11111));
        tbl.push_back(mk(5'b01000, 0, 5'b00000, 0, 5'b00000, 1, 0, 0, 3, 1, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b01000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 3, 1, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b01000, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 3, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 3, 0, 5'b00000, 5'b11111));
        // Priority with channel 1 masked, then unmasked
        tbl.push_back(mk(5'b10010, 1, 5'b11101, 0, 5'b00000, 0, 0, 0, 3, 0, 5'b00000, 5'b11101));
        tbl.push_back(mk(5'b10010, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 3, 0, 5'b00000, 5'b11101));
        tbl.push_back(mk(5'b10010, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 3, 0, 5'b10010, 5'b11101));
        tbl.push_back(mk(5'b10010, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 4, 0, 5'b10010, 5'b11101));
        tbl.push_back(mk(5'b10010, 0, 5'b00000, 0, 5'b00000, 1, 0, 0, 4, 1, 5'b00010, 5'b11101));
        tbl.push_back(mk(5'b10010, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 4, 0, 5'b00010, 5'b11101));
        tbl.push_back(mk(5'b10010, 1, 5'b11111, 0, 5'b00000, 0, 0, 0, 4, 0, 5'b00010, 5'b11111));
        tbl.push_back(mk(5'b10010, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 1, 0, 5'b00010, 5'b11111));
        // Software clear while requesting channel 1
        tbl.push_back(mk(5'b10010, 0, 5'b00000, 1, 5'b00010, 0, 0, 1, 1, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 1, 0, 5'b00000, 5'b11111));
        // Collision: second edge on channel 2 lands on the Ack edge
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 1, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 1, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 1, 0, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 2, 0, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 2, 0, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 2, 0, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 2, 0, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 2, 0, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 1, 0, 0, 2, 1, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 2, 1, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 2, 0, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 2, 0, 5'b00100, 5'b11111));
        tbl.push_back(mk(5'b00100, 0, 5'b00000, 0, 5'b00000, 1, 0, 0, 2, 1, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 2, 0, 5'b00000, 5'b11111));
        // Ack and Done while idle are ignored
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 1, 1, 0, 2, 0, 5'b00000, 5'b11111));
        // Level channel 0 held high; Ack and Done together in REQ
        tbl.push_back(mk(5'b00001, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 2, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b00001, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 2, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b00001, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 2, 0, 5'b00001, 5'b11111));
        tbl.push_back(mk(5'b00001, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 0, 0, 5'b00001, 5'b11111));
        tbl.push_back(mk(5'b00001, 0, 5'b00000, 0, 5'b00000, 1, 1, 0, 0, 1, 5'b00001, 5'b11111));
        tbl.push_back(mk(5'b00001, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 1, 5'b00001, 5'b11111));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 1, 0, 0, 0, 5'b00001, 5'b11111));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 0, 0, 5'b00001, 5'b11111));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 1, 5'b00001, 0, 0, 1, 0, 0, 5'b00000, 5'b11111));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111));
        // Masked pending bit stays pending but is not requested
        tbl.push_back(mk(5'b00000, 1, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000));
        tbl.push_back(mk(5'b10000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000));
        tbl.push_back(mk(5'b10000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000));
        tbl.push_back(mk(5'b10000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b10000, 5'b00000));
        tbl.push_back(mk(5'b10000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b10000, 5'b00000));
        tbl.push_back(mk(5'b10000, 1, 5'b11111, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b10000, 5'b11111));
        tbl.push_back(mk(5'b10000, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 4, 0, 5'b10000, 5'b11111));
        // Masking in REQ withdraws the request without clearing pending
        tbl.push_back(mk(5'b10000, 1, 5'b00000, 0, 5'b00000, 0, 0, 1, 4, 0, 5'b10000, 5'b00000));
        tbl.push_back(mk(5'b10000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 4, 0, 5'b10000, 5'b00000));
        tbl.push_back(mk(5'b00000, 0, 5'b00000, 1, 5'b10000, 0, 0, 0, 4, 0, 5'b00000, 5'b00000));

        // Hold reset for a few cycles, release away from the rising edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Reach SERVICE on channel 1 with pending 10110, then reset mid-flight.
        step(mk(5'b00010, 1, 5'b11111, 0, 5'b00000, 0, 0, 0, 4, 0, 5'b00000, 5'b11111), "rst_seq0");
        step(mk(5'b00010, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 4, 0, 5'b00000, 5'b11111), "rst_seq1");
        step(mk(5'b00010, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 4, 0, 5'b00010, 5'b11111), "rst_seq2");
        step(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 1, 1, 0, 5'b00010, 5'b11111), "rst_seq3");
        step(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 1, 0, 0, 1, 1, 5'b00000, 5'b11111), "rst_seq4");
        step(mk(5'b10110, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 1, 1, 5'b00000, 5'b11111), "rst_seq5");
        step(mk(5'b10110, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 1, 1, 5'b00000, 5'b11111), "rst_seq6");
        step(mk(5'b10110, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 1, 1, 5'b10110, 5'b11111), "rst_seq7");

        // Asynchronous reset: outputs must clear without waiting for a clock edge.
        @(negedge clk);
        clr            = 1'b0;
        irq_in         = '0;
        mask_write     = 1'b0;
        pend_clr_write = 1'b0;
        irq_ack        = 1'b0;
        irq_done       = 1'b0;
        exp_q.push_back('0);
        #1;
        check_out("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;

        step(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000), "post_reset0");
        step(mk(5'b00000, 1, 5'b11111, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111), "post_reset1");
        step(mk(5'b00000, 0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 5'b11111), "post_reset2");

        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL leftover: got %0d unconsumed expectations, need 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised interrupt controller that replaces the fixed four-switch/one-button interrupt register. It gathers NUM_CH raw asynchronous sources (switches, buttons, peripherals), synchronises them, and latches each event into a pending bit. Per-channel masking and fixed priority select a single request to the processor control unit, which completes an acknowledge/done handshake. Pending and mask state are readable; software clears pending bits and writes the mask.

## Interface
- NUM_CH, 5, number of interrupt channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per input (2..3)
- EDGE_MASK, all ones, per-channel mode: 1 = rising-edge triggered, 0 = level triggered
- ID_W (derived), ceil(log2(NUM_CH)), min 1, width of IRQ_ID
- CLK  in  1  system clock, all state on rising edge
- CLR  in  1  asynchronous active-low reset
- IRQ_In  in  NUM_CH  raw asynchronous interrupt sources
- Mask_Data  in  NUM_CH  new mask value (1 = enabled)
- Mask_Write  in  1  load Mask_Data into mask this cycle
- Pend_Clr_Data  in  NUM_CH  write-one-to-clear pattern for pending bits
- Pend_Clr_Write  in  1  apply Pend_Clr_Data this cycle
- IRQ_Ack  in  1  CPU accepts the current request
- IRQ_Done  in  1  CPU finished servicing (end of interrupt)
- IRQ_Req  out  1  request to CPU
- IRQ_ID  out  ID_W  index of requested/in-service channel
- In_Service  out  1  handler active
- Pending  out  NUM_CH  pending register
- Mask  out  NUM_CH  mask register

## Operation
- Each IRQ_In bit passes through SYNC_STAGES flops (reset 0), then a one-flop history for edge detect.
- Event: edge channel = sync high and history low; level channel = sync high (re-sets every cycle while high).
- Pending next = (Pending & ~clear) | event; clear = (Pend_Clr_Write ? Pend_Clr_Data : 0) | ack-clear one-hot. Event wins over any clear in the same cycle (no event lost).
- Mask loads on Mask_Write; masking never clears Pending, only hides it from arbitration.
- Arbitration: eligible = Pending & Mask; lowest index wins.
- FSM, state register reset to IDLE:
  - IDLE: if eligible != 0, latch winner into IRQ_ID, go REQ.
  - REQ: IRQ_Req = 1, IRQ_ID held. IRQ_Ack -> clear Pending[IRQ_ID] (subject to event-wins), go SERVICE. If the latched bit is lost (cleared by software or masked) without Ack -> IDLE, IRQ_Req drops; no re-arbitration inside REQ.
  - SERVICE: In_Service = 1, IRQ_ID held, IRQ_Req = 0, new events still latch. IRQ_Done -> IDLE. IRQ_Ack ignored.
- IRQ_Done outside SERVICE ignored. Ack and Done same cycle in REQ: Ack taken, Done ignored.
- Reset values: IRQ_Req 0, IRQ_ID 0, In_Service 0, Pending 0, Mask 0 (all disabled), sync/history 0.

## Timing
- IRQ_In edge first sampled at CLK edge t -> Pending bit set after edge t+SYNC_STAGES.
- Pending/Mask eligible at edge u -> FSM enters REQ, IRQ_Req high after edge u+1 (registered outputs only).
- Ack sampled at edge a -> Pending bit clear and In_Service high after edge a; Done at d -> In_Service low after d; earliest next IRQ_Req after d+1.
- Mask_Write/Pend_Clr_Write visible on Mask/Pending the cycle after the write edge.
- CLR low at any time forces reset values immediately; handshake mid-flight is abandoned. Release is synchronous to CLK by the surrounding reset logic.

## Test plan
- Reset: CLR low mid-SERVICE with Pending=5'b10110 -> all outputs 0 immediately, FSM IDLE after release.
- Single edge: Mask=5'b11111, IRQ_In[3] rises at t -> Pending=5'b01000 at t+2, IRQ_Req=1 and IRQ_ID=3 at t+3; Ack -> Pending=0, In_Service=1; Done -> In_Service=0.
- Priority/mask: IRQ_In[4] and [1] rise together, Mask=5'b11101 -> IRQ_ID=4 first; after Done, Mask_Write 5'b11111 -> IRQ_ID=1 next.
- Collision: new edge on channel 2 in the exact cycle Ack clears channel 2 -> Pending[2] stays 1, second request follows Done.
- Level mode (EDGE_MASK bit0=0): IRQ_In[0] held high through Ack -> Pending[0] re-sets next cycle; edge channel held high sets only once.
- Software clear: in REQ on channel 1, Pend_Clr_Write with 5'b00010 -> Pending[1]=0, IRQ_Req drops next cycle, FSM IDLE, no Ack needed.
